// File: rtl/btn_conditioner.sv
// N-channel push-button conditioner: synchronizer, counter debounce, rise/fall pulses, press strobe.
// Optional auto-repeat on press is enabled by defining BTN_COND_REPEAT_EN.

module btn_chan #(
  parameter int SYNC_STAGES  = 2,
  parameter int DB_CYCLES    = 50000,
  parameter int REPEAT_DELAY = 5000000,
  parameter int REPEAT_RATE  = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_press
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level, r_rise, r_fall;
  logic                   w_s, w_done, w_level_nxt;

  assign w_s         = r_sync[SYNC_STAGES-1];
  assign w_done      = (w_s != r_level) && (r_cnt == CW'(DB_CYCLES - 1));
  assign w_level_nxt = w_done ? w_s : r_level;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
      r_rise <= w_done & w_s;
      r_fall <= w_done & ~w_s;
      // Any sample agreeing with the current level restarts the stability count.
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_level <= w_s;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

`ifdef BTN_COND_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW  = (RMAX > 1) ? $clog2(RMAX + 1) : 1;

  logic [RCW-1:0] r_rc;
  logic           r_sub, r_press;
  logic [RCW-1:0] w_tgt;

  assign w_tgt = r_sub ? RCW'(REPEAT_RATE - 1) : RCW'(REPEAT_DELAY - 1);

  // Repeat timing restarts on the rise edge and is held cleared whenever level is (or becomes) 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rc    <= '0;
      r_sub   <= 1'b0;
      r_press <= 1'b0;
    end else if (!w_level_nxt || !r_level) begin
      r_rc    <= '0;
      r_sub   <= 1'b0;
      r_press <= w_level_nxt & ~r_level;
    end else if (r_rc == w_tgt) begin
      r_rc    <= '0;
      r_sub   <= 1'b1;
      r_press <= 1'b1;
    end else begin
      r_rc    <= r_rc + 1'b1;
      r_press <= 1'b0;
    end
  end

  assign o_press = r_press;
`else
  assign o_press = r_rise;
`endif
endmodule

module btn_conditioner #(
  parameter int N            = 5,
  parameter int SYNC_STAGES  = 2,
  parameter int DB_CYCLES    = 50000,
  parameter int REPEAT_DELAY = 5000000,
  parameter int REPEAT_RATE  = 1000000
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_in,
  output logic [N-1:0] o_level,
  output logic [N-1:0] o_rise,
  output logic [N-1:0] o_fall,
  output logic [N-1:0] o_press
);
  btn_chan #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_chan [N-1:0] (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_in   (i_in),
    .o_level(o_level),
    .o_rise (o_rise),
    .o_fall (o_fall),
    .o_press(o_press)
  );
endmodule
